// File: rtl/board_state_if.sv
// board_state_if: command handshake (cmd_*) and registered cell query port (q_*) between the board controller and its clients
interface board_state_if #(parameter int IDX_W = 5);
  logic             cmd_valid;
  logic             cmd_op;
  logic [IDX_W-1:0] cmd_x;
  logic [IDX_W-1:0] cmd_y;
  logic             cmd_ready;
  logic [IDX_W-1:0] q_x;
  logic [IDX_W-1:0] q_y;
  logic [1:0]       q_state;
  logic [3:0]       q_num;
  modport master (output cmd_valid, cmd_op, cmd_x, cmd_y, q_x, q_y, input cmd_ready, q_state, q_num);
  modport slave  (input cmd_valid, cmd_op, cmd_x, cmd_y, q_x, q_y, output cmd_ready, q_state, q_num);
endinterface

// File: rtl/board_state_ctrl.sv
// board_state_ctrl: unified flag/reveal cell store with BFS flood fill; ports clk/rst, new_game+level+mine_arr+mines game setup, bus (cmd handshake, cell query), mines_left/explode_latched/game_won/busy status
module board_state_ctrl #(
  parameter int MAX_SIZE  = 16,
  parameter int SIZE_EASY = 8,
  parameter int SIZE_MED  = 10,
  parameter int SIZE_HARD = 16,
  parameter int IDX_W     = 5,
  parameter int CNT_W     = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           new_game,
  input  logic [1:0]                     level,
  input  logic [MAX_SIZE*MAX_SIZE-1:0]   mine_arr,
  input  logic [CNT_W-1:0]               mines,
  board_state_if.slave                   bus,
  output logic [CNT_W-1:0]               mines_left,
  output logic                           explode_latched,
  output logic                           game_won,
  output logic                           busy
);
  localparam int N  = MAX_SIZE * MAX_SIZE;
  localparam int AW = $clog2(N);
  localparam int CW = IDX_W + 1;
  typedef enum logic [2:0] {IDLE, CHECK, POP, SCAN, LOST} state_t;
  function automatic logic [AW-1:0] cidx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return AW'(int'(y) * MAX_SIZE + int'(x));
  endfunction
  // coordinates wrap below zero to a large value, so a single < side test rejects both edges
  function automatic logic [3:0] nbr_cnt(input logic [N-1:0] m, input logic [CW-1:0] s,
                                         input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [CW-1:0] nx, ny;
    nbr_cnt = 4'd0;
    for (int d = 0; d < 9; d++) begin
      nx = x + CW'(d % 3) - CW'(1);
      ny = y + CW'(d / 3) - CW'(1);
      if (d != 4 && nx < s && ny < s) nbr_cnt = nbr_cnt + 4'(m[cidx(nx, ny)]);
    end
  endfunction
  state_t state, state_n;
  logic [1:0] cells [N];
  logic [2*CW-1:0] fifo [N];
  logic [CNT_W-1:0] wr_ptr, rd_ptr, flags, revealed, target;
  logic [CW-1:0] side, cx, cy, cur_x, cur_y, tx, ty, qx, qy;
  logic [3:0] nd, tn;
  logic [2:0] dir;
  logic [1:0] ts, wd;
  logic op, accept, we, push, flag_inc, flag_dec, rev_inc, explode_set, t_in, t_mine, q_in;
  assign bus.cmd_ready = state == IDLE && !explode_latched && !game_won;
  assign busy = state == CHECK || state == POP || state == SCAN;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign target = CNT_W'(side) * CNT_W'(side) - mines;
  assign qx = CW'(bus.q_x);
  assign qy = CW'(bus.q_y);
  assign q_in = qx < side && qy < side;
  // one target cell per cycle: the latched command cell in CHECK, the current neighbour in SCAN
  always_comb begin
    nd = dir < 3'd4 ? {1'b0, dir} : {1'b0, dir} + 4'd1;
    tx = state == SCAN ? cur_x + CW'(nd % 4'd3) - CW'(1) : cx;
    ty = state == SCAN ? cur_y + CW'(nd / 4'd3) - CW'(1) : cy;
    t_in = tx < side && ty < side;
    ts = t_in ? cells[cidx(tx, ty)] : 2'd0;
    t_mine = t_in && mine_arr[cidx(tx, ty)];
    tn = nbr_cnt(mine_arr, side, tx, ty);
    state_n = state;
    we = 1'b0;
    wd = 2'd0;
    push = 1'b0;
    flag_inc = 1'b0;
    flag_dec = 1'b0;
    rev_inc = 1'b0;
    explode_set = 1'b0;
    case (state)
      IDLE: state_n = accept ? CHECK : IDLE;
      CHECK: begin
        state_n = IDLE;
        if (t_in && !op) begin
          we = ts < 2'd2;
          wd = ts == 2'd0 ? 2'd1 : 2'd0;
          flag_inc = ts == 2'd0;
          flag_dec = ts == 2'd1;
        end else if (t_in && ts == 2'd0 && t_mine) begin
          we = 1'b1;
          wd = 2'd3;
          explode_set = 1'b1;
          state_n = LOST;
        end else if (t_in && ts == 2'd0) begin
          we = 1'b1;
          wd = 2'd2;
          rev_inc = 1'b1;
          push = tn == 4'd0;
          state_n = tn == 4'd0 ? POP : IDLE;
        end
      end
      POP: state_n = rd_ptr == wr_ptr ? IDLE : SCAN;
      SCAN: begin
        if (t_in && ts == 2'd0 && !t_mine) begin
          we = 1'b1;
          wd = 2'd2;
          rev_inc = 1'b1;
          push = tn == 4'd0;
        end
        state_n = dir == 3'd7 ? POP : SCAN;
      end
      LOST: state_n = LOST;
      default: state_n = IDLE;
    endcase
  end
  // each cell is pushed at most once per game, so the pointers never pass N and need no wrap
  always_ff @(posedge clk) if (push) fifo[wr_ptr[AW-1:0]] <= {ty, tx};
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state <= IDLE;
      cells <= '{default: 2'd0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      flags <= '0;
      revealed <= '0;
      mines_left <= '0;
      explode_latched <= 1'b0;
      game_won <= 1'b0;
      bus.q_state <= 2'd0;
      bus.q_num <= 4'd0;
      side <= level == 2'd0 ? CW'(SIZE_EASY) : level == 2'd1 ? CW'(SIZE_MED) : CW'(SIZE_HARD);
      op <= 1'b0;
      cx <= '0;
      cy <= '0;
      cur_x <= '0;
      cur_y <= '0;
      dir <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && accept) begin
        op <= bus.cmd_op;
        cx <= CW'(bus.cmd_x);
        cy <= CW'(bus.cmd_y);
      end
      if (we) cells[cidx(tx, ty)] <= wd;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (state == POP && rd_ptr != wr_ptr) begin
        {cur_y, cur_x} <= fifo[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
        dir <= 3'd0;
      end else if (state == SCAN) dir <= dir + 3'd1;
      flags <= flags + CNT_W'(flag_inc) - CNT_W'(flag_dec);
      revealed <= revealed + CNT_W'(rev_inc);
      mines_left <= mines > flags ? mines - flags : '0;
      explode_latched <= explode_latched | explode_set;
      game_won <= game_won | (revealed == target && !explode_latched);
      bus.q_state <= q_in ? cells[cidx(qx, qy)] : 2'd0;
      bus.q_num <= q_in ? nbr_cnt(mine_arr, side, qx, qy) : 4'd0;
    end
  end
endmodule

// File: tb/tb_board_state_ctrl.sv
// tb_board_state_ctrl: directed scenario bench for board_state_ctrl
module tb_board_state_ctrl;
  localparam int MS = 16, IW = 5, CW = 9;
  logic clk = 1'b0, rst = 1'b1, new_game = 1'b0;
  logic [1:0] level = 2'd0;
  logic [MS*MS-1:0] mine_arr = '0;
  logic [CW-1:0] mines = '0, mines_left;
  logic explode_latched, game_won, busy;
  int errors = 0, checks = 0;
  board_state_if #(.IDX_W(IW)) bus();
  board_state_ctrl #(.MAX_SIZE(MS), .SIZE_EASY(8), .SIZE_MED(10), .SIZE_HARD(16), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .level(level), .mine_arr(mine_arr), .mines(mines),
    .bus(bus.slave), .mines_left(mines_left), .explode_latched(explode_latched), .game_won(game_won), .busy(busy));
  always #5 clk = ~clk;
  function automatic logic [MS*MS-1:0] mbit(input int x, input int y);
    mbit = '0;
    mbit[y*MS+x] = 1'b1;
  endfunction
  task automatic start_game(input logic [1:0] lv, input logic [MS*MS-1:0] m, input int nm);
    @(negedge clk);
    level = lv;
    mine_arr = m;
    mines = CW'(nm);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask
  task automatic do_cmd(input logic op, input int x, input int y);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_x = IW'(x);
    bus.cmd_y = IW'(y);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic query(input int x, input int y, output logic [1:0] st, output logic [3:0] n);
    @(negedge clk);
    bus.q_x = IW'(x);
    bus.q_y = IW'(y);
    @(negedge clk);
    st = bus.q_state;
    n = bus.q_num;
  endtask
  task automatic test_reset;
    logic [1:0] st;
    logic [3:0] n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (explode_latched !== 1'b0) begin errors++; $display("FAIL reset_explode: got %b want 0", explode_latched); end
    checks++; if (game_won !== 1'b0) begin errors++; $display("FAIL reset_won: got %b want 0", game_won); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
    query(2, 2, st, n);
    checks++; if (st !== 2'd0 || n !== 4'd0) begin errors++; $display("FAIL reset_query: got %0d/%0d want 0/0", st, n); end
  endtask
  task automatic test_flood_win;
    logic [1:0] st;
    logic [3:0] n;
    int cyc;
    start_game(2'd0, mbit(0, 0), 1);
    do_cmd(1'b1, 7, 7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flood_busy: got %b want 1", busy); end
    wait_idle(cyc);
    checks++; if (cyc != 542) begin errors++; $display("FAIL flood_cycles: got %0d want 542", cyc); end
    checks++; if (game_won !== 1'b1) begin errors++; $display("FAIL flood_won: got %b want 1", game_won); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL flood_ready: got %b want 0", bus.cmd_ready); end
    query(1, 1, st, n);
    checks++; if (st !== 2'd2 || n !== 4'd1) begin errors++; $display("FAIL flood_q11: got %0d/%0d want 2/1", st, n); end
    query(0, 0, st, n);
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL flood_q00: got %0d want 0", st); end
    query(6, 3, st, n);
    checks++; if (st !== 2'd2 || n !== 4'd0) begin errors++; $display("FAIL flood_q63: got %0d/%0d want 2/0", st, n); end
    checks++; if (mines_left !== 9'd1) begin errors++; $display("FAIL flood_mines_left: got %0d want 1", mines_left); end
  endtask
  task automatic test_explode;
    logic [1:0] st;
    logic [3:0] n;
    start_game(2'd0, mbit(3, 3), 1);
    do_cmd(1'b1, 3, 3);
    @(negedge clk);
    checks++; if (explode_latched !== 1'b1) begin errors++; $display("FAIL explode_latch: got %b want 1", explode_latched); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL explode_ready: got %b want 0", bus.cmd_ready); end
    query(3, 3, st, n);
    checks++; if (st !== 2'd3) begin errors++; $display("FAIL explode_q33: got %0d want 3", st); end
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 1'b1;
    bus.cmd_x = IW'(5);
    bus.cmd_y = IW'(5);
    repeat (5) @(negedge clk);
    bus.cmd_valid = 1'b0;
    query(5, 5, st, n);
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL explode_no_accept: got %0d want 0", st); end
    checks++; if (game_won !== 1'b0) begin errors++; $display("FAIL explode_won: got %b want 0", game_won); end
    start_game(2'd0, mbit(3, 3), 1);
    checks++; if (explode_latched !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL explode_clear: got %b/%b want 0/1", explode_latched, bus.cmd_ready); end
    query(3, 3, st, n);
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL explode_cleared_cell: got %0d want 0", st); end
  endtask
  task automatic test_flags;
    logic [1:0] st;
    logic [3:0] n;
    int cyc;
    start_game(2'd0, '0, 2);
    @(negedge clk);
    checks++; if (mines_left !== 9'd2) begin errors++; $display("FAIL flag_init: got %0d want 2", mines_left); end
    do_cmd(1'b0, 1, 1); wait_idle(cyc); @(negedge clk);
    checks++; if (mines_left !== 9'd1) begin errors++; $display("FAIL flag_one: got %0d want 1", mines_left); end
    do_cmd(1'b0, 2, 2); wait_idle(cyc); @(negedge clk);
    checks++; if (mines_left !== 9'd0) begin errors++; $display("FAIL flag_two: got %0d want 0", mines_left); end
    do_cmd(1'b0, 3, 3); wait_idle(cyc); @(negedge clk);
    checks++; if (mines_left !== 9'd0) begin errors++; $display("FAIL flag_sat: got %0d want 0", mines_left); end
    do_cmd(1'b0, 1, 1); wait_idle(cyc); @(negedge clk);
    checks++; if (mines_left !== 9'd0) begin errors++; $display("FAIL flag_toggle: got %0d want 0", mines_left); end
    query(1, 1, st, n);
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL flag_unflag_q11: got %0d want 0", st); end
    do_cmd(1'b0, 3, 3); wait_idle(cyc); @(negedge clk);
    checks++; if (mines_left !== 9'd1) begin errors++; $display("FAIL flag_unsat: got %0d want 1", mines_left); end
    do_cmd(1'b1, 2, 2);
    wait_idle(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL flag_reveal_busy: got %0d want 1", cyc); end
    query(2, 2, st, n);
    checks++; if (st !== 2'd1) begin errors++; $display("FAIL flag_reveal_noop: got %0d want 1", st); end
  endtask
  task automatic test_hard_fill_abort;
    logic [1:0] st;
    logic [3:0] n;
    int cyc;
    start_game(2'd2, '0, 0);
    do_cmd(1'b0, 5, 5); wait_idle(cyc);
    do_cmd(1'b1, 0, 0);
    wait_idle(cyc);
    checks++; if (cyc != 2297) begin errors++; $display("FAIL hard_cycles: got %0d want 2297", cyc); end
    query(5, 5, st, n);
    checks++; if (st !== 2'd1) begin errors++; $display("FAIL hard_flag_kept: got %0d want 1", st); end
    query(15, 15, st, n);
    checks++; if (st !== 2'd2) begin errors++; $display("FAIL hard_far_corner: got %0d want 2", st); end
    checks++; if (game_won !== 1'b0) begin errors++; $display("FAIL hard_not_won: got %b want 0", game_won); end
    start_game(2'd3, '0, 0);
    do_cmd(1'b1, 0, 0);
    query(0, 0, st, n);
    repeat (15) @(negedge clk);
    checks++; if (st !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL abort_pre: got %0d/%b want 2/1", st, busy); end
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    checks++; if (busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b/%b want 0/1", busy, bus.cmd_ready); end
    checks++; if (bus.q_state !== 2'd0) begin errors++; $display("FAIL abort_qreset: got %0d want 0", bus.q_state); end
    query(1, 1, st, n);
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL abort_hidden: got %0d want 0", st); end
  endtask
  task automatic test_out_of_range;
    logic [1:0] st;
    logic [3:0] n;
    int cyc;
    start_game(2'd1, mbit(10, 3), 1);
    do_cmd(1'b1, 12, 3);
    wait_idle(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL oor_busy: got %0d want 1", cyc); end
    query(12, 3, st, n);
    checks++; if (st !== 2'd0 || n !== 4'd0) begin errors++; $display("FAIL oor_query: got %0d/%0d want 0/0", st, n); end
    query(9, 3, st, n);
    checks++; if (n !== 4'd0) begin errors++; $display("FAIL oor_edge_count: got %0d want 0", n); end
  endtask
  task automatic test_numbered;
    logic [1:0] st;
    logic [3:0] n;
    int cyc;
    start_game(2'd0, mbit(0, 0) | mbit(1, 0) | mbit(0, 1), 3);
    do_cmd(1'b1, 1, 1);
    wait_idle(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL num_busy: got %0d want 1", cyc); end
    query(1, 1, st, n);
    checks++; if (st !== 2'd2 || n !== 4'd3) begin errors++; $display("FAIL num_q11: got %0d/%0d want 2/3", st, n); end
    query(2, 2, st, n);
    checks++; if (st !== 2'd0 || n !== 4'd0) begin errors++; $display("FAIL num_q22: got %0d/%0d want 0/0", st, n); end
    query(0, 0, st, n);
    checks++; if (n !== 4'd2) begin errors++; $display("FAIL num_corner: got %0d want 2", n); end
    do_cmd(1'b1, 2, 1);
    wait_idle(cyc);
    query(2, 1, st, n);
    checks++; if (st !== 2'd2 || n !== 4'd1) begin errors++; $display("FAIL num_back_to_back: got %0d/%0d want 2/1", st, n); end
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 1'b0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.q_x = '0;
    bus.q_y = '0;
    test_reset;
    test_flood_win;
    test_explode;
    test_flags;
    test_hard_fill_abort;
    test_out_of_range;
    test_numbered;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
